mdu_unit: RTL and testbench
===========================

MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 No parameters; data width fixed at 32 bits.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 op_e  in  3  EX-stage MDU opcode: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
REQ-005 src_a  in  32  EX-stage rs operand, already forwarded; the dividend / multiplicand.
REQ-006 src_b  in  32  EX-stage rt operand, already forwarded; the divisor / multiplier.
REQ-007 stall_e  in  1  EX stage held this cycle (memory stall or MDU not ready).
REQ-008 flush_e  in  1  EX-stage instruction cancelled this cycle (exception); has priority over stall_e.
REQ-009 mdu_ready  out  1  low while an MDU operation occupies EX; drives the hazard unit's EX/F/D stall and MEM bubble.
REQ-010 hi_o  out  32  architectural HI register.
REQ-011 lo_o  out  32  architectural LO register.

Function
REQ-012 The FSM SHALL have states IDLE, MUL, DIV, FIX and DONE.
REQ-013 mdu_ready SHALL be combinational: 0 in MUL/DIV/FIX, 0 in IDLE when op_e is mult/multu/div/divu, and 1 otherwise.
REQ-014 In IDLE with op_e mult/multu/div/divu and flush_e=0, operands and signedness SHALL be latched: mult/multu -> MUL, div/divu -> DIV with the iteration counter set to 0.
REQ-015 MUL SHALL register the 64-bit product, signed for mult and unsigned for multu, then go to DONE; mdu_ready is low for exactly 2 cycles, including the issue cycle.
REQ-016 DIV SHALL run restoring shift-subtract on 32-bit magnitudes, one quotient bit per cycle, for 32 cycles (counter 0..31), then go to FIX.
REQ-017 FIX SHALL apply signs for div: quotient negated when operand signs differ, remainder takes the dividend's sign. It then goes to DONE, so mdu_ready is low for exactly 34 cycles.
REQ-018 The MUL/DIV/FIX sequence SHALL advance regardless of stall_e.
REQ-019 In DONE, mdu_ready=1; when stall_e=0 and flush_e=0, HI <= product[63:32] or remainder, LO <= product[31:0] or quotient, and the FSM returns to IDLE.
REQ-020 In DONE with stall_e=1, the FSM SHALL hold DONE with the result intact and SHALL NOT re-issue.
REQ-021 flush_e=1 in any state SHALL force IDLE next cycle with no HI/LO write; in IDLE it SHALL suppress both starting an operation and mthi/mtlo.
REQ-022 In IDLE, mthi/mtlo SHALL write src_a to HI/LO when stall_e=0 and flush_e=0, with no stall generated.
REQ-023 A zero divisor SHALL take the full 34-cycle latency and produce LO=0xFFFFFFFF and HI=src_a, for both div and divu.
REQ-024 div 0x80000000 / 0xFFFFFFFF SHALL produce LO=0x80000000 and HI=0x00000000 (wrap, no trap).
REQ-025 HI/LO writes SHALL be visible on hi_o/lo_o the cycle after commit, so an mfhi/mflo entering EX next cycle reads the new value.
REQ-026 Latched operands SHALL be used after issue; later changes on src_a/src_b/op_e SHALL NOT affect a running operation.

Reset
REQ-027 resetn=0 at a clock edge SHALL set state=IDLE, hi_o=0, lo_o=0, counter=0, and clear internal operand/partial registers to 0, including when reset arrives mid-operation.
REQ-028 During and after reset with op_e=none, mdu_ready SHALL read 1.

Verification
REQ-029 mult with src_a=0xFFFFFFFF, src_b=2, then op_e=none -> mdu_ready low cycles 0-1, high cycle 2; after commit HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with multu -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-030 div with src_a=0xFFFFFFF9 (-7), src_b=2 -> mdu_ready low 34 cycles; after commit LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 100/7 -> LO=14, HI=2.
REQ-031 divu with src_a=0x12345678, src_b=0 -> after 34 cycles LO=0xFFFFFFFF, HI=0x12345678.
REQ-032 div issued, flush_e pulsed at DIV cycle 10 -> IDLE next cycle, mdu_ready=1, hi_o/lo_o unchanged; a new mult issued afterwards completes correctly.
REQ-033 Reach DONE with stall_e held 5 cycles -> mdu_ready stays 1, HI/LO unchanged until stall_e drops, single commit, no re-issue.
REQ-034 mthi 0xA5A5A5A5 then mtlo 0x5A5A5A5A back-to-back -> mdu_ready never low; HI/LO updated on consecutive cycles. Reset asserted at DIV cycle 20 -> IDLE, HI=LO=0.

Source files
------------

// File: rtl/mdu_unit.sv
// MDU for the EX stage: 2-cycle multiply, 34-cycle restoring divide, HI/LO.
// Results commit to HI/LO from DONE once EX is neither stalled nor flushed.
module mdu_unit (
   input  logic        clk,
   input  logic        resetn,
   input  logic [2:0]  op_e,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        stall_e,
   input  logic        flush_e,
   output logic        mdu_ready,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL  = 3'd1,
      DIV  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   // a_q: multiplicand, then dividend/quotient shift register, then LO result
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   // rem_q: partial remainder, then HI result
   logic [31:0] rem_q, rem_d;
   logic        sgn_q, sgn_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        is_mul;
   logic        is_div;
   logic        op_signed;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [63:0] ext_a;
   logic [63:0] ext_b;
   logic [63:0] prod;
   logic [32:0] shifted;
   logic [32:0] diff;

   assign is_mul    = (op_e == OP_MULT) || (op_e == OP_MULTU);
   assign is_div    = (op_e == OP_DIV) || (op_e == OP_DIVU);
   assign op_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
   assign a_mag     = (op_signed && src_a[31]) ? -src_a : src_a;
   assign b_mag     = (op_signed && src_b[31]) ? -src_b : src_b;

   // Sign-extending to 64 bits lets one unsigned multiplier serve both
   assign ext_a = {{32{sgn_q & a_q[31]}}, a_q};
   assign ext_b = {{32{sgn_q & b_q[31]}}, b_q};
   assign prod  = ext_a * ext_b;

   assign shifted = {rem_q, a_q[31]};
   assign diff    = shifted - {1'b0, b_q};

   assign hi_o = hi_q;
   assign lo_o = lo_q;

   // Next-state, datapath and ready decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      rem_d     = rem_q;
      sgn_d     = sgn_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      mdu_ready = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (is_mul || is_div) mdu_ready = 1'b0;
            if (!flush_e) begin
               if (is_mul) begin
                  state_d = MUL;
                  a_d     = src_a;
                  b_d     = src_b;
                  sgn_d   = op_signed;
               end else if (is_div) begin
                  state_d = DIV;
                  a_d     = a_mag;
                  b_d     = b_mag;
                  rem_d   = 32'd0;
                  cnt_d   = 5'd0;
                  sgn_d   = op_signed;
                  // A zero divisor keeps the all-ones quotient unsigned
                  qneg_d  = op_signed & (src_a[31] ^ src_b[31]) & (|src_b);
                  rneg_d  = op_signed & src_a[31];
               end else if (!stall_e && op_e == OP_MTHI) begin
                  hi_d = src_a;
               end else if (!stall_e && op_e == OP_MTLO) begin
                  lo_d = src_a;
               end
            end
         end
         MUL: begin
            mdu_ready = 1'b0;
            rem_d     = prod[63:32];
            a_d       = prod[31:0];
            state_d   = DONE;
         end
         DIV: begin
            mdu_ready = 1'b0;
            if (!diff[32]) begin
               rem_d = diff[31:0];
               a_d   = {a_q[30:0], 1'b1};
            end else begin
               rem_d = shifted[31:0];
               a_d   = {a_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = FIX;
         end
         FIX: begin
            mdu_ready = 1'b0;
            a_d       = qneg_q ? -a_q : a_q;
            rem_d     = rneg_q ? -rem_q : rem_q;
            state_d   = DONE;
         end
         DONE: begin
            if (!stall_e) begin
               hi_d    = rem_q;
               lo_d    = a_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush_e) begin
         state_d = IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   // State and datapath registers with synchronous clear
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         rem_q   <= 32'd0;
         sgn_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         sgn_q   <= sgn_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: latency, results, flush, stall and reset.
module tb_mdu_unit;

   localparam logic [2:0] OP_NONE  = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   logic        clk;
   logic        resetn;
   logic [2:0]  op_e;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        stall_e;
   logic        flush_e;
   logic        mdu_ready;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int total = 0;
   int bad   = 0;
   int low;

   mdu_unit dut (
      .clk       (clk),
      .resetn    (resetn),
      .op_e      (op_e),
      .src_a     (src_a),
      .src_b     (src_b),
      .stall_e   (stall_e),
      .flush_e   (flush_e),
      .mdu_ready (mdu_ready),
      .hi_o      (hi_o),
      .lo_o      (lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Issue an op, scramble the inputs afterwards, count ready-low cycles.
   // Returns with the DUT sitting in DONE (result not yet committed).
   task automatic run(input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, output int n);
      op_e  = op;
      src_a = a;
      src_b = b;
      #1;
      n = mdu_ready ? 0 : 1;
      step();
      op_e  = OP_NONE;
      src_a = 32'hDEADBEEF;
      src_b = 32'h00000003;
      #1;
      while (!mdu_ready && n < 100) begin
         n++;
         step();
      end
   endtask

   initial begin
      resetn  = 1'b0;
      op_e    = OP_NONE;
      src_a   = 32'd0;
      src_b   = 32'd0;
      stall_e = 1'b0;
      flush_e = 1'b0;
      step();
      step();
      chk("rst_ready", {31'd0, mdu_ready}, 32'd1);
      chk("rst_hi", hi_o, 32'd0);
      chk("rst_lo", lo_o, 32'd0);
      resetn = 1'b1;
      step();

      run(OP_MULT, 32'hFFFFFFFF, 32'd2, low);
      chk("mult_lat", low, 32'd2);
      chk("mult_ready_done", {31'd0, mdu_ready}, 32'd1);
      step();
      chk("mult_hi", hi_o, 32'hFFFFFFFF);
      chk("mult_lo", lo_o, 32'hFFFFFFFE);

      run(OP_MULTU, 32'hFFFFFFFF, 32'd2, low);
      chk("multu_lat", low, 32'd2);
      step();
      chk("multu_hi", hi_o, 32'h00000001);
      chk("multu_lo", lo_o, 32'hFFFFFFFE);

      run(OP_DIV, 32'hFFFFFFF9, 32'd2, low);
      chk("div_lat", low, 32'd34);
      step();
      chk("div_lo", lo_o, 32'hFFFFFFFD);
      chk("div_hi", hi_o, 32'hFFFFFFFF);

      run(OP_DIVU, 32'd100, 32'd7, low);
      chk("divu_lat", low, 32'd34);
      step();
      chk("divu_lo", lo_o, 32'd14);
      chk("divu_hi", hi_o, 32'd2);

      run(OP_DIVU, 32'h12345678, 32'd0, low);
      chk("divu0_lat", low, 32'd34);
      step();
      chk("divu0_lo", lo_o, 32'hFFFFFFFF);
      chk("divu0_hi", hi_o, 32'h12345678);

      run(OP_DIV, 32'hFFFFFFF9, 32'd0, low);
      chk("div0_lat", low, 32'd34);
      step();
      chk("div0_lo", lo_o, 32'hFFFFFFFF);
      chk("div0_hi", hi_o, 32'hFFFFFFF9);

      run(OP_DIV, 32'h80000000, 32'hFFFFFFFF, low);
      step();
      chk("divovf_lo", lo_o, 32'h80000000);
      chk("divovf_hi", hi_o, 32'h00000000);

      // flush mid-divide leaves HI/LO alone
      op_e  = OP_DIV;
      src_a = 32'd100;
      src_b = 32'd7;
      step();
      op_e = OP_NONE;
      for (int i = 0; i < 10; i++) step();
      flush_e = 1'b1;
      step();
      flush_e = 1'b0;
      #1;
      chk("flush_ready", {31'd0, mdu_ready}, 32'd1);
      chk("flush_hi", hi_o, 32'h00000000);
      chk("flush_lo", lo_o, 32'h80000000);
      step();
      chk("flush_lo2", lo_o, 32'h80000000);
      run(OP_MULT, 32'd3, 32'd5, low);
      chk("postflush_lat", low, 32'd2);
      step();
      chk("postflush_hi", hi_o, 32'd0);
      chk("postflush_lo", lo_o, 32'd15);

      // stall held in DONE: no commit, no re-issue
      run(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, low);
      stall_e = 1'b1;
      op_e    = OP_MULT;
      src_a   = 32'd7;
      src_b   = 32'd9;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_ready", {31'd0, mdu_ready}, 32'd1);
         chk("stall_lo", lo_o, 32'd15);
      end
      stall_e = 1'b0;
      op_e    = OP_NONE;
      step();
      chk("stall_commit_hi", hi_o, 32'd0);
      chk("stall_commit_lo", lo_o, 32'd1);
      step();
      chk("stall_noreissue", {31'd0, mdu_ready}, 32'd1);
      chk("stall_lo_hold", lo_o, 32'd1);

      // mthi / mtlo back to back, then a flushed mthi
      op_e  = OP_MTHI;
      src_a = 32'hA5A5A5A5;
      #1;
      chk("mthi_ready", {31'd0, mdu_ready}, 32'd1);
      step();
      chk("mthi_hi", hi_o, 32'hA5A5A5A5);
      op_e  = OP_MTLO;
      src_a = 32'h5A5A5A5A;
      #1;
      chk("mtlo_ready", {31'd0, mdu_ready}, 32'd1);
      step();
      chk("mtlo_lo", lo_o, 32'h5A5A5A5A);
      chk("mtlo_hi", hi_o, 32'hA5A5A5A5);
      op_e    = OP_MTHI;
      src_a   = 32'h00000001;
      flush_e = 1'b1;
      step();
      flush_e = 1'b0;
      op_e    = OP_NONE;
      chk("mthi_flush_hi", hi_o, 32'hA5A5A5A5);

      // reset in the middle of a divide
      op_e  = OP_DIV;
      src_a = 32'd100;
      src_b = 32'd7;
      step();
      op_e = OP_NONE;
      for (int i = 0; i < 20; i++) step();
      resetn = 1'b0;
      step();
      chk("midrst_ready", {31'd0, mdu_ready}, 32'd1);
      chk("midrst_hi", hi_o, 32'd0);
      chk("midrst_lo", lo_o, 32'd0);
      resetn = 1'b1;
      step();
      run(OP_DIVU, 32'd100, 32'd7, low);
      chk("postrst_lat", low, 32'd34);
      step();
      chk("postrst_lo", lo_o, 32'd14);
      chk("postrst_hi", hi_o, 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
